// File: rtl/floor_seek_comparator.sv
// rtl/floor_seek_comparator.sv - latched-target floor comparator with debounced up/down and arrival pulse
module floor_seek_comparator #(
  parameter int WIDTH  = 10,
  parameter int STABLE = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] current,
  input  logic             en,
  output logic             up,
  output logic             down,
  output logic             arrived,
  output logic             busy
);

  localparam int CW = $clog2(STABLE + 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(STABLE);
  localparam logic [CW:0]   CNT_MAX_W = (CW + 1)'(STABLE);

  typedef enum logic {IDLE, SEEK} state_t;
  typedef enum logic [1:0] {RAW_UP = 2'd0, RAW_DN = 2'd1, RAW_EQ = 2'd2} raw_t;

  state_t           state, state_d;
  raw_t             raw_q, raw_d, raw_now;
  logic [WIDTH-1:0] target_q, target_d;
  logic [CW-1:0]    cnt, cnt_d, cnt_new;
  logic [CW:0]      cnt_plus;
  logic             up_d, down_d, arrived_d, busy_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      target_q <= '0;
      raw_q    <= RAW_EQ;
      cnt      <= '0;
      up       <= 1'b0;
      down     <= 1'b0;
      arrived  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      target_q <= target_d;
      raw_q    <= raw_d;
      cnt      <= cnt_d;
      up       <= up_d;
      down     <= down_d;
      arrived  <= arrived_d;
      busy     <= busy_d;
    end
  end

  // Run-length of identical samples; restarts on a new raw result or after (re)load.
  always_comb begin
    if (target_q > current)      raw_now = RAW_UP;
    else if (target_q < current) raw_now = RAW_DN;
    else                         raw_now = RAW_EQ;

    cnt_plus = {1'b0, cnt} + {{CW{1'b0}}, 1'b1};
    if (cnt == '0 || raw_now != raw_q)
      cnt_new = {{(CW-1){1'b0}}, 1'b1};
    else if (cnt_plus >= CNT_MAX_W)
      cnt_new = CNT_MAX;
    else
      cnt_new = cnt_plus[CW-1:0];
  end

  always_comb begin
    state_d   = state;
    target_d  = target_q;
    raw_d     = raw_q;
    cnt_d     = cnt;
    up_d      = up;
    down_d    = down;
    arrived_d = 1'b0;
    busy_d    = busy;

    case (state)
      IDLE: begin
        if (load) begin
          target_d = target;
          cnt_d    = '0;
          state_d  = SEEK;
          busy_d   = 1'b1;
        end
      end
      SEEK: begin
        if (load) begin
          target_d = target;
          cnt_d    = '0;
        end else if (en) begin
          raw_d = raw_now;
          cnt_d = cnt_new;
          if (cnt_new == CNT_MAX) begin
            case (raw_now)
              RAW_UP: begin
                up_d   = 1'b1;
                down_d = 1'b0;
              end
              RAW_DN: begin
                up_d   = 1'b0;
                down_d = 1'b1;
              end
              default: begin
                up_d      = 1'b0;
                down_d    = 1'b0;
                arrived_d = 1'b1;
                busy_d    = 1'b0;
                state_d   = IDLE;
                cnt_d     = '0;
              end
            endcase
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_floor_seek_comparator.sv
// tb/tb_floor_seek_comparator.sv - table vectors, corner sequences and random run against a run-length model
module tb_floor_seek_comparator;

  localparam int WIDTH  = 10;
  localparam int STABLE = 3;
  localparam int MAXV   = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             load;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] current;
  logic             en;
  logic             up, down, arrived, busy;

  int total = 0;
  int bad   = 0;

  floor_seek_comparator #(.WIDTH(WIDTH), .STABLE(STABLE)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .target  (target),
    .current (current),
    .en      (en),
    .up      (up),
    .down    (down),
    .arrived (arrived),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1);
  end

  typedef struct {
    bit       ld;
    int       tg;
    int       cur;
    bit       e;
    bit [3:0] exp; // {up, down, arrived, busy}
  } vec_t;

  vec_t vq[$];

  // Reference: count of consecutive identical comparisons since the last (re)load.
  bit m_seek, m_up, m_down, m_arr, m_busy;
  int m_tgt, m_last, m_run;

  function automatic void model_reset();
    m_seek = 0; m_up = 0; m_down = 0; m_arr = 0; m_busy = 0;
    m_tgt = 0; m_last = 0; m_run = 0;
  endfunction

  function automatic void model_step(bit ld, int tg, int cur, bit e);
    int r;
    m_arr = 0;
    if (!m_seek) begin
      if (ld) begin
        m_seek = 1; m_busy = 1; m_tgt = tg; m_run = 0;
      end
    end else if (ld) begin
      m_tgt = tg; m_run = 0;
    end else if (e) begin
      r = (m_tgt > cur) ? 1 : (m_tgt < cur) ? -1 : 0;
      if (m_run > 0 && r == m_last) m_run++;
      else begin
        m_last = r; m_run = 1;
      end
      if (m_run >= STABLE) begin
        if (r == 1) begin
          m_up = 1; m_down = 0;
        end else if (r == -1) begin
          m_up = 0; m_down = 1;
        end else begin
          m_up = 0; m_down = 0; m_arr = 1; m_busy = 0; m_seek = 0;
        end
      end
    end
  endfunction

  task automatic check(input string name, input bit [3:0] act, input bit [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got {up,down,arr,busy}=%b want %b", name, act, exp);
    end
  endtask

  task automatic step(input bit ld, input int tg, input int cur, input bit e);
    load    = ld;
    target  = tg[WIDTH-1:0];
    current = cur[WIDTH-1:0];
    en      = e;
    @(posedge clk);
    #1;
  endtask

  function automatic void add(bit ld, int tg, int cur, bit e, bit [3:0] exp);
    vec_t v;
    v.ld = ld; v.tg = tg; v.cur = cur; v.e = e; v.exp = exp;
    vq.push_back(v);
  endfunction

  function automatic int pick();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return MAXV;
    if (k == 1) return MAXV - 1;
    return $urandom_range(0, 5);
  endfunction

  initial begin
    reset_n = 1'b0; load = 0; target = '0; current = '0; en = 0;
    #1;
    check("reset_async", {up, down, arrived, busy}, 4'b0000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_hold", {up, down, arrived, busy}, 4'b0000);
    reset_n = 1'b1;

    // scenario 1/2: approach from below, then arrive
    add(1, 5, 2, 1, 4'b0001); add(0, 5, 2, 1, 4'b0001); add(0, 5, 2, 1, 4'b0001);
    add(0, 5, 2, 1, 4'b1001); add(0, 5, 3, 1, 4'b1001);
    add(0, 5, 5, 1, 4'b1001); add(0, 5, 5, 1, 4'b1001); add(0, 5, 5, 1, 4'b0010);
    add(0, 5, 5, 1, 4'b0000);
    // scenario 3: glitches rejected, then steady overshoot
    add(1, 5, 2, 1, 4'b0001); add(0, 0, 2, 1, 4'b0001); add(0, 0, 2, 1, 4'b0001);
    add(0, 0, 2, 1, 4'b1001); add(0, 0, 4, 1, 4'b1001); add(0, 0, 6, 1, 4'b1001);
    add(0, 0, 4, 1, 4'b1001); add(0, 0, 6, 1, 4'b1001); add(0, 0, 6, 1, 4'b1001);
    add(0, 0, 6, 1, 4'b0101);
    // scenario 4: retarget holds filtered outputs; load beats arrival
    add(1, 9, 5, 1, 4'b0101); add(0, 0, 5, 1, 4'b0101); add(0, 0, 5, 1, 4'b0101);
    add(0, 0, 5, 1, 4'b1001);
    add(1, 1, 5, 1, 4'b1001); add(0, 0, 5, 1, 4'b1001); add(0, 0, 5, 1, 4'b1001);
    add(0, 0, 5, 1, 4'b0101);
    add(1, 5, 5, 1, 4'b0101); add(0, 0, 5, 1, 4'b0101); add(0, 0, 5, 1, 4'b0101);
    add(1, 9, 5, 1, 4'b0101); add(0, 0, 5, 1, 4'b0101); add(0, 0, 5, 1, 4'b0101);
    add(0, 0, 5, 1, 4'b1001);
    // scenario 5: en=0 freezes the filter mid-count
    add(0, 0, 12, 1, 4'b1001); add(0, 0, 12, 1, 4'b1001);
    for (int i = 0; i < 5; i++) add(0, 0, (i % 2) ? 3 : 12, 0, 4'b1001);
    add(0, 0, 12, 1, 4'b0101);
    // scenario 6: extremes and equal-at-load
    add(1, MAXV, 0, 1, 4'b0101); add(0, 0, 0, 1, 4'b0101); add(0, 0, 0, 1, 4'b0101);
    add(0, 0, 0, 1, 4'b1001);
    add(1, 0, MAXV, 1, 4'b1001); add(0, 0, MAXV, 1, 4'b1001); add(0, 0, MAXV, 1, 4'b1001);
    add(0, 0, MAXV, 1, 4'b0101);
    add(1, 0, 0, 1, 4'b0101); add(0, 0, 0, 1, 4'b0101); add(0, 0, 0, 1, 4'b0101);
    add(0, 0, 0, 1, 4'b0010);
    add(1, 0, 0, 1, 4'b0001); add(0, 0, 0, 1, 4'b0001); add(0, 0, 0, 1, 4'b0001);
    add(0, 0, 0, 1, 4'b0010); add(0, 0, 7, 1, 4'b0000); add(0, 0, 9, 1, 4'b0000);

    foreach (vq[i]) begin
      step(vq[i].ld, vq[i].tg, vq[i].cur, vq[i].e);
      check($sformatf("vec%0d", i), {up, down, arrived, busy}, vq[i].exp);
    end

    // reset asserted mid-SEEK between edges, then idle until next load
    step(1, 8, 1, 1);
    step(0, 0, 1, 1); step(0, 0, 1, 1); step(0, 0, 1, 1);
    check("pre_reset_up", {up, down, arrived, busy}, 4'b1001);
    #2 reset_n = 1'b0;
    #1;
    check("reset_mid_seek", {up, down, arrived, busy}, 4'b0000);
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, i * 3, 1);
      check($sformatf("post_reset_idle%0d", i), {up, down, arrived, busy}, 4'b0000);
    end

    // randomized run against the reference model
    reset_n = 1'b0; #1; reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      bit ld, e;
      int tg, cur;
      ld  = ($urandom_range(0, 11) == 0);
      e   = ($urandom_range(0, 7) != 0);
      tg  = pick();
      cur = pick();
      model_step(ld, tg, cur, e);
      step(ld, tg, cur, e);
      check($sformatf("rand%0d", i), {up, down, arrived, busy}, {m_up, m_down, m_arr, m_busy});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
